// File: rtl/reorder_logic_dispatch_pkg.sv
// Shared definitions for the re-order logic dispatch block:
// width helpers and the dispatch FSM state encoding.
package reorder_logic_pkg;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // A one-entry selector or pool still needs a one-bit field.
    function automatic int sel_width(input int num_queues);
        return (clog2(num_queues) < 1) ? 1 : clog2(num_queues);
    endfunction

    function automatic int id_width(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OPEN = 1'b1;

endpackage

// File: rtl/reorder_logic_dispatch_if.sv
// Request, trace-push and commit signals between the dispatch block
// and its environment; master is the dispatch side.
interface reorder_logic_dispatch_if #(
    parameter int NUM_QUEUES = 4,
    parameter int DEPTH      = 64
);
    import reorder_logic_pkg::*;

    localparam int SEL_WIDTH = sel_width(NUM_QUEUES);
    localparam int ID_WIDTH  = id_width(DEPTH);

    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [SEL_WIDTH-1:0]  req_sel_i;
    logic                  req_last_i;
    logic                  req_close_i;
    logic [ID_WIDTH-1:0]   req_id_o;
    logic [NUM_QUEUES-1:0] queue_issue_o;
    logic                  full_i;
    logic                  trace_id_push_o;
    logic [ID_WIDTH-1:0]   trace_id_value_o;
    logic                  trace_push_o;
    logic [SEL_WIDTH-1:0]  trace_sel_o;
    logic                  trace_break_o;
    logic                  trace_update_o;
    logic                  commit_id_valid_i;
    logic [ID_WIDTH-1:0]   commit_id_value_i;
    logic                  commit_id_pull_o;
    logic                  err_o;

    modport master (
        input  req_valid_i, req_sel_i, req_last_i, req_close_i, full_i,
               commit_id_valid_i, commit_id_value_i,
        output req_ready_o, req_id_o, queue_issue_o, trace_id_push_o,
               trace_id_value_o, trace_push_o, trace_sel_o, trace_break_o,
               trace_update_o, commit_id_pull_o, err_o
    );

    modport slave (
        output req_valid_i, req_sel_i, req_last_i, req_close_i, full_i,
               commit_id_valid_i, commit_id_value_i,
        input  req_ready_o, req_id_o, queue_issue_o, trace_id_push_o,
               trace_id_value_o, trace_push_o, trace_sel_o, trace_break_o,
               trace_update_o, commit_id_pull_o, err_o
    );

endinterface

// File: rtl/reorder_logic_dispatch_id_allocator.sv
// Circular ID pool: allocation and free pointers plus outstanding count.
// Commit-order checking is built only with REORDER_DISPATCH_CHECK_EN.
module reorder_id_allocator
    import reorder_logic_pkg::*;
#(
    parameter int  DEPTH    = 64,
    localparam int ID_WIDTH = id_width(DEPTH)
) (
    input  logic                clk_i,
    input  logic                arsn_i,
    input  logic                alloc,
    input  logic                pull,
    input  logic [ID_WIDTH-1:0] commit_value,
    output logic [ID_WIDTH-1:0] alloc_ptr,
    output logic                available,
    output logic                err
);

    localparam logic [ID_WIDTH:0] DEPTH_COUNT = (ID_WIDTH + 1)'(DEPTH);

    logic [ID_WIDTH-1:0] free_ptr;
    logic [ID_WIDTH:0]   outstanding;
    logic                underflow;
    logic                do_release;

    assign underflow  = (outstanding == '0);
    assign do_release = pull & ~underflow;
    assign available  = (outstanding < DEPTH_COUNT);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge arsn_i) begin
        if (!arsn_i) begin
            alloc_ptr   <= '0;
            free_ptr    <= '0;
            outstanding <= '0;
        end else begin
            if (alloc)
                alloc_ptr <= alloc_ptr + 1'b1;
            if (do_release)
                free_ptr <= free_ptr + 1'b1;
            case ({alloc, do_release})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

`ifdef REORDER_DISPATCH_CHECK_EN
    logic err_q;

    // IDs must retire in allocation order; any slip or underflow is sticky.
    always_ff @(posedge clk_i or negedge arsn_i) begin
        if (!arsn_i)
            err_q <= 1'b0;
        else if (pull && (underflow || (commit_value != free_ptr)))
            err_q <= 1'b1;
    end

    assign err = err_q;
`else
    logic unused_commit;

    assign unused_commit = ^commit_value;
    assign err           = 1'b0;
`endif

endmodule

// File: rtl/reorder_logic_dispatch.sv
// Producer end of the re-order trace protocol: one ID per transaction,
// registered trace/issue pulses. Optional check: REORDER_DISPATCH_CHECK_EN.
module reorder_logic_dispatch
    import reorder_logic_pkg::*;
#(
    parameter int   NUM_QUEUES = 4,
    parameter int   DEPTH      = 64,
    parameter logic BREAKPOINT = 1'b1
) (
    input logic                      clk_i,
    input logic                      arsn_i,
    reorder_logic_dispatch_if.master bus
);

    localparam int SEL_WIDTH = sel_width(NUM_QUEUES);
    localparam int ID_WIDTH  = id_width(DEPTH);

    logic [0:0]            state;
    logic [ID_WIDTH-1:0]   open_id;
    logic [ID_WIDTH-1:0]   alloc_ptr;
    logic                  available;
    logic                  err;
    logic                  is_open;
    logic                  ready;
    logic                  accept;
    logic                  alloc;
    logic [NUM_QUEUES-1:0] issue_next;

    assign is_open = (state == ST_OPEN);
    assign ready   = ~bus.full_i & ~(is_open & bus.req_close_i) & (is_open | available);
    assign accept  = bus.req_valid_i & ready;
    assign alloc   = accept & ~is_open;

    assign bus.req_ready_o      = ready;
    assign bus.req_id_o         = is_open ? open_id : alloc_ptr;
    assign bus.commit_id_pull_o = bus.commit_id_valid_i;
    assign bus.err_o            = err;

    reorder_id_allocator #(
        .DEPTH (DEPTH)
    ) u_id_allocator (
        .clk_i        (clk_i),
        .arsn_i       (arsn_i),
        .alloc        (alloc),
        .pull         (bus.commit_id_valid_i),
        .commit_value (bus.commit_id_value_i),
        .alloc_ptr    (alloc_ptr),
        .available    (available),
        .err          (err)
    );

    always_comb begin
        issue_next = '0;
        if (accept)
            issue_next[bus.req_sel_i] = 1'b1;
    end

    // open_id remembers the transaction ID because alloc_ptr has already moved on.
    always_ff @(posedge clk_i or negedge arsn_i) begin
        if (!arsn_i) begin
            state   <= ST_IDLE;
            open_id <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept && !bus.req_last_i) begin
                        state   <= ST_OPEN;
                        open_id <= alloc_ptr;
                    end
                end
                default: begin
                    if (bus.req_close_i || (accept && bus.req_last_i))
                        state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arsn_i) begin
        if (!arsn_i) begin
            bus.trace_id_push_o  <= 1'b0;
            bus.trace_id_value_o <= '0;
            bus.trace_push_o     <= 1'b0;
            bus.trace_sel_o      <= '0;
            bus.trace_break_o    <= 1'b0;
            bus.trace_update_o   <= 1'b0;
            bus.queue_issue_o    <= '0;
        end else begin
            bus.trace_id_push_o <= alloc;
            if (alloc)
                bus.trace_id_value_o <= alloc_ptr;
            bus.trace_push_o <= accept;
            if (accept) begin
                bus.trace_sel_o   <= bus.req_sel_i;
                bus.trace_break_o <= bus.req_last_i ? BREAKPOINT : ~BREAKPOINT;
            end
            bus.trace_update_o <= is_open & bus.req_close_i;
            bus.queue_issue_o  <= issue_next;
        end
    end

endmodule

// File: tb/tb_reorder_logic_dispatch.sv
// Scoreboard bench for reorder_logic_dispatch with DEPTH=4, NUM_QUEUES=4.
// Directed vectors queue expected trace pulses; a negedge monitor checks them.
module tb_reorder_logic_dispatch;

    localparam int NQ    = 4;
    localparam int DEPTH = 4;

`ifdef REORDER_DISPATCH_CHECK_EN
    localparam logic CHECK_EN = 1'b1;
`else
    localparam logic CHECK_EN = 1'b0;
`endif

    typedef struct {
        int         due;
        logic       idPush;
        logic [1:0] idValue;
        logic       push;
        logic [1:0] sel;
        logic       brk;
        logic       update;
        logic [3:0] issue;
    } exp_t;

    logic clk_i  = 1'b0;
    logic arsn_i = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t expq[$];
    exp_t monExp;

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    reorder_logic_dispatch_if #(.NUM_QUEUES(NQ), .DEPTH(DEPTH)) bus ();

    reorder_logic_dispatch #(
        .NUM_QUEUES (NQ),
        .DEPTH      (DEPTH),
        .BREAKPOINT (1'b1)
    ) dut (
        .clk_i  (clk_i),
        .arsn_i (arsn_i),
        .bus    (bus.master)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic driveInputs(input logic v, input int sel, input logic last, input logic close,
                               input logic full, input logic cvalid, input int cval);
        bus.req_valid_i       = v;
        bus.req_sel_i         = 2'(sel);
        bus.req_last_i        = last;
        bus.req_close_i       = close;
        bus.full_i            = full;
        bus.commit_id_valid_i = cvalid;
        bus.commit_id_value_i = 2'(cval);
    endtask

    // One cycle of stimulus; the expected trace pulse (if any) is due next cycle.
    task automatic applyStimulus(input logic v, input int sel, input logic last, input logic close,
                                 input logic full, input logic cvalid, input int cval,
                                 input logic expReady, input int expId,
                                 input logic expIdPush, input logic expUpdate);
        exp_t e;
        @(posedge clk_i);
        #1;
        driveInputs(v, sel, last, close, full, cvalid, cval);
        #1;
        checkOutput("req_ready", bus.req_ready_o, expReady);
        checkOutput("req_id", bus.req_id_o, expId);
        checkOutput("commit_pull", bus.commit_id_pull_o, cvalid);
        if (v && expReady) begin
            e.due     = cyc + 1;
            e.idPush  = expIdPush;
            e.idValue = 2'(expId);
            e.push    = 1'b1;
            e.sel     = 2'(sel);
            e.brk     = last;
            e.update  = 1'b0;
            e.issue   = 4'(1 << sel);
            expq.push_back(e);
        end
        if (expUpdate) begin
            e.due     = cyc + 1;
            e.idPush  = 1'b0;
            e.idValue = 2'd0;
            e.push    = 1'b0;
            e.sel     = 2'd0;
            e.brk     = 1'b0;
            e.update  = 1'b1;
            e.issue   = 4'd0;
            expq.push_back(e);
        end
    endtask

    task automatic idleCycle();
        @(posedge clk_i);
        #1;
        driveInputs(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        #1;
    endtask

    task automatic resetDut();
        idleCycle();
        idleCycle();
        arsn_i = 1'b0;
        #2;
        checkOutput("rst_trace_push", bus.trace_push_o, 0);
        checkOutput("rst_update", bus.trace_update_o, 0);
        checkOutput("rst_err", bus.err_o, 0);
        repeat (2) @(posedge clk_i);
        #1;
        arsn_i = 1'b1;
        #1;
        checkOutput("rst_req_id", bus.req_id_o, 0);
        checkOutput("rst_ready", bus.req_ready_o, 1);
    endtask

    always @(negedge clk_i) begin
        if (arsn_i) begin
            if (bus.trace_id_push_o || bus.trace_push_o || bus.trace_update_o || (|bus.queue_issue_o)) begin
                checks++;
                if (expq.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_output cyc=%0d id_push=%0b push=%0b update=%0b issue=%b",
                             cyc, bus.trace_id_push_o, bus.trace_push_o, bus.trace_update_o, bus.queue_issue_o);
                end else begin
                    monExp = expq.pop_front();
                    if ((bus.trace_id_push_o !== monExp.idPush) ||
                        (monExp.idPush && (bus.trace_id_value_o !== monExp.idValue)) ||
                        (bus.trace_push_o !== monExp.push) ||
                        (monExp.push && ((bus.trace_sel_o !== monExp.sel) || (bus.trace_break_o !== monExp.brk))) ||
                        (bus.trace_update_o !== monExp.update) ||
                        (bus.queue_issue_o !== monExp.issue)) begin
                        failures++;
                        $display("[TB] FAIL trace_entry cyc=%0d got idp=%0b id=%0d push=%0b sel=%0d brk=%0b upd=%0b issue=%b expected idp=%0b id=%0d push=%0b sel=%0d brk=%0b upd=%0b issue=%b",
                                 cyc, bus.trace_id_push_o, bus.trace_id_value_o, bus.trace_push_o,
                                 bus.trace_sel_o, bus.trace_break_o, bus.trace_update_o, bus.queue_issue_o,
                                 monExp.idPush, monExp.idValue, monExp.push, monExp.sel, monExp.brk,
                                 monExp.update, monExp.issue);
                    end
                end
            end else if (expq.size() != 0 && expq[0].due <= cyc) begin
                checks++;
                failures++;
                $display("[TB] FAIL missing_output cyc=%0d got none expected entry due at cyc=%0d", cyc, expq[0].due);
                void'(expq.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        driveInputs(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        arsn_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("init_trace_push", bus.trace_push_o, 0);
        checkOutput("init_err", bus.err_o, 0);
        arsn_i = 1'b1;

        $display("[TB] single-entry transaction");
        applyStimulus(1, 2, 1, 0, 0, 0, 0, 1, 0, 1, 0);
        idleCycle();
        checkOutput("id_after_single", bus.req_id_o, 1);

        $display("[TB] three-entry transaction");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        applyStimulus(1, 3, 1, 0, 0, 0, 0, 1, 1, 0, 0);
        idleCycle();
        checkOutput("id_after_three", bus.req_id_o, 2);

        $display("[TB] close");
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 1, 2, 1, 0);
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 2, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 1, 3, 0, 0);

        $display("[TB] exhaustion, wrap and simultaneous alloc/commit");
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 1, 3, 1, 0);
        applyStimulus(1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 0, 1, 1, 1, 0, 1, 0);
        applyStimulus(1, 2, 1, 0, 0, 0, 0, 1, 1, 1, 0);
        applyStimulus(1, 3, 1, 0, 0, 0, 0, 0, 2, 0, 0);

        $display("[TB] full_i blocking");
        applyStimulus(0, 0, 0, 0, 0, 1, 2, 0, 2, 0, 0);
        applyStimulus(1, 3, 1, 0, 1, 0, 0, 0, 2, 0, 0);
        applyStimulus(1, 3, 0, 0, 0, 0, 0, 1, 2, 1, 0);
        applyStimulus(1, 0, 1, 0, 1, 0, 0, 0, 2, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 1, 2, 0, 0);
        idleCycle();
        checkOutput("id_after_open_at_limit", bus.req_id_o, 3);
        checkOutput("ready_at_limit", bus.req_ready_o, 0);
        checkOutput("err_in_order", bus.err_o, 0);

        $display("[TB] commit order error");
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 3, 0, 0);
        idleCycle();
        checkOutput("err_mismatch", bus.err_o, CHECK_EN);
        idleCycle();
        checkOutput("err_sticky", bus.err_o, CHECK_EN);
        resetDut();

        applyStimulus(1, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 3, 1, 1, 0, 0);
        idleCycle();
        checkOutput("err_value3", bus.err_o, CHECK_EN);
        resetDut();

        $display("[TB] underflow pull");
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        idleCycle();
        checkOutput("err_underflow", bus.err_o, CHECK_EN);
        checkOutput("ready_after_underflow", bus.req_ready_o, 1);
        applyStimulus(1, 2, 1, 0, 0, 0, 0, 1, 0, 1, 0);

        $display("[TB] reset mid-transaction");
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        idleCycle();
        checkOutput("open_id_held", bus.req_id_o, 1);
        resetDut();
        idleCycle();
        idleCycle();

        checkOutput("queue_drained", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reorder_logic_dispatch.md
Name: reorder_logic_dispatch

Overview:
- Producer end of the re-order logic trace protocol. Accepts a stream of sub-requests grouped into transactions.
- Allocates one ID per transaction and drives the trace-ID and trace-entry push interface into the re-order logic.
- Emits a one-hot issue pulse toward the selected queue for each sub-request.
- Consumes the committed-ID stream and recycles those IDs back into the allocation pool.

Parameters:
- NUM_QUEUES, 4, number of downstream queues.
- DEPTH, 64, number of IDs; also the maximum number of outstanding transactions. Power of two.
- BREAKPOINT, 1'b1, trace_break_o value that marks the last entry of a transaction.

Ports:
- clk_i  in  1  clock.
- arsn_i  in  1  asynchronous active-low reset.
- req_valid_i  in  1  sub-request valid.
- req_ready_o  out  1  sub-request accepted when valid and ready are both high.
- req_sel_i  in  SEL_WIDTH  target queue of the sub-request; SEL_WIDTH = clog2(NUM_QUEUES).
- req_last_i  in  1  sub-request is the last of its transaction.
- req_close_i  in  1  close the open transaction without a new entry.
- req_id_o  out  ID_WIDTH  ID of the current or next transaction; ID_WIDTH = clog2(DEPTH).
- queue_issue_o  out  NUM_QUEUES  one-hot issue pulse.
- full_i  in  1  re-order logic full.
- trace_id_push_o  out  1  push a new ID.
- trace_id_value_o  out  ID_WIDTH  ID value being pushed.
- trace_push_o  out  1  push a trace entry.
- trace_sel_o  out  SEL_WIDTH  queue selector of the trace entry.
- trace_break_o  out  1  breakpoint flag of the trace entry.
- trace_update_o  out  1  mark the last pushed entry as the breakpoint.
- commit_id_valid_i  in  1  committed ID available.
- commit_id_value_i  in  ID_WIDTH  committed ID value.
- commit_id_pull_o  out  1  pull the committed ID.
- err_o  out  1  sticky commit-order error.

Behaviour:
- Reset (arsn_i low, asynchronous) clears:
  - state to IDLE;
  - alloc_ptr, free_ptr, outstanding and err_o to 0;
  - all push, update and issue outputs, trace_id_value_o, trace_sel_o and trace_break_o to 0.
- Reset mid-transaction discards the open transaction. No update pulse is emitted.
- FSM is two states, IDLE and OPEN:
  - IDLE to OPEN: accepted request with req_last_i=0.
  - IDLE stays IDLE: accepted request with req_last_i=1 (single-entry transaction).
  - OPEN to IDLE: accepted request with req_last_i=1, or req_close_i.
- Handshake and ready:
  - req_ready_o = ~full_i & ~(state==OPEN & req_close_i) & (state==OPEN | outstanding<DEPTH).
  - Ready is combinational; there is no dependency on req_valid_i.
- Accepted request in IDLE (allocates an ID). Next cycle:
  - trace_id_push_o=1 with trace_id_value_o=alloc_ptr;
  - trace_push_o=1 with trace_sel_o=req_sel_i and trace_break_o = req_last_i ? BREAKPOINT : ~BREAKPOINT;
  - queue_issue_o[req_sel_i]=1.
  - alloc_ptr increments modulo DEPTH; outstanding increments.
- Accepted request in OPEN: same as IDLE, but with no ID push and no allocation.
- All trace outputs are registered, giving 1-cycle latency from acceptance. Each pulse lasts 1 cycle.
- req_id_o = alloc_ptr in IDLE; in OPEN it is the ID of the open transaction.
- req_close_i:
  - In OPEN: trace_update_o=1 next cycle, state goes to IDLE, and no request is accepted that cycle.
  - In IDLE: ignored.
- Commit path:
  - commit_id_pull_o = commit_id_valid_i (combinational, always accepts).
  - Each pull increments free_ptr modulo DEPTH and decrements outstanding.
  - Allocation and release in the same cycle leave outstanding unchanged.
- Boundaries:
  - outstanding==DEPTH in IDLE blocks new transactions; OPEN continues unaffected.
  - full_i blocks all acceptance.
  - Pointers wrap from DEPTH-1 to 0.
  - outstanding never underflows: a pull with outstanding==0 sets err_o in the check build and is otherwise ignored.

Optional Feature:
- REORDER_DISPATCH_CHECK_EN defined: on each pull, commit_id_value_i must equal free_ptr; a mismatch or an underflow pull sets err_o, which stays set until reset.
- Not defined: err_o is tied to 0 and the comparator is removed.

Decomposition:
- Shared package reorder_logic_pkg holds:
  - the clog2 function;
  - ID_WIDTH/SEL_WIDTH derivation;
  - the FSM state constants ST_IDLE and ST_OPEN.
- One sub-module, reorder_id_allocator, owns:
  - alloc_ptr, free_ptr and the outstanding counter;
  - the available flag;
  - the optional order check.
- The top level holds the FSM and the registered trace/issue outputs.

Test Plan:
- Single transaction: reset; send one request with sel=2, last=1 → next cycle trace_id_push_o=1 with value 0, trace_push_o=1, trace_sel_o=2, trace_break_o=1, queue_issue_o=4'b0100; outstanding=1.
- Three-entry transaction: sel 0,1,3 with last on the third → exactly one ID push; breaks 0,0,1; req_id_o held at 0 throughout; FSM returns to IDLE.
- Close: sel=1 with last=0, then req_close_i → trace_update_o pulse; req_ready_o=0 during the close cycle; the next request gets ID 1.
- Exhaustion and wrap: DEPTH=4; four single-entry transactions → req_ready_o=0 in IDLE; one commit of ID 0 → ready restores and the next ID is 0.
- Simultaneous events: allocation and commit pull in the same cycle → outstanding unchanged; full_i=1 → no pushes or issues.
- Check build: commit value 3 when free_ptr=0 → err_o=1 and stays high until reset; non-check build keeps err_o=0.
